reg_file_access_ctrl: RTL
=========================

// Module: reg_file_access_ctrl
// PURPOSE
// Master-side controller for the Register_file port (WrEn/RdEn/Address/WrData/RdData).
// Receives a byte stream of commands with a valid/ready handshake and issues register-file writes and reads.
// Returns read data on a valid/ready response port.
// Sits between the frame receiver and Register_file in the system-control path.
// PARAMETERS
// DATA_WIDTH   16     register word width; must be a multiple of FRAME_WIDTH
// ADDR_WIDTH   4      register-file address width (<= FRAME_WIDTH)
// FRAME_WIDTH  8      command frame width
// WR_CMD       8'hAA  write-command opcode
// RD_CMD       8'hBB  read-command opcode
// RD_LATENCY   1      cycles from the RdEn cycle to valid RdData (>= 1)
// PORTS
// CLK          in   1            system clock, rising edge
// RST          in   1            synchronous reset, active-high
// In_Data      in   FRAME_WIDTH  command frame
// In_Valid     in   1            In_Data valid
// In_Ready     out  1            controller accepts a frame
// WrEn         out  1            register-file write strobe
// RdEn         out  1            register-file read strobe
// Address      out  ADDR_WIDTH   register-file address
// WrData       out  DATA_WIDTH   register-file write data
// RdData       in   DATA_WIDTH   register-file read data
// Out_Data     out  DATA_WIDTH   read response word
// Out_Valid    out  1            Out_Data valid
// Out_Ready    in   1            downstream accepts the response
// Cmd_Err      out  1            one-cycle pulse on an unknown opcode
// BEHAVIOUR
// - A frame is accepted on a rising edge with In_Valid && In_Ready.
// - In_Ready is decoded from state: 1 in IDLE, WR_ADDR, WR_DATA and RD_ADDR; otherwise 0.
// - In_Ready is forced to 0 while RST is high.
// - Reset: state IDLE, beat count 0.
//   - WrEn, RdEn, Address, WrData, Out_Data, Out_Valid and Cmd_Err are all 0.
//   - All these outputs are registered.
// - IDLE: on an accepted frame:
//   - WR_CMD -> WR_ADDR.
//   - RD_CMD -> RD_ADDR.
//   - Any other value -> Cmd_Err=1 for exactly one cycle; stay in IDLE.
// - WR_ADDR / RD_ADDR: latch In_Data[ADDR_WIDTH-1:0] into Address (upper bits ignored).
//   - WR_ADDR -> WR_DATA with beat count 0; RD_ADDR -> RD_EXEC.
// - WR_DATA: accepts DATA_WIDTH/FRAME_WIDTH beats, least-significant frame first, into WrData.
//   - After the last beat -> WR_EXEC.
// - WR_EXEC: WrEn=1 for exactly one cycle, immediately after the last beat is accepted -> IDLE.
// - RD_EXEC: RdEn=1 for exactly one cycle -> RD_WAIT.
// - RD_WAIT: samples RdData RD_LATENCY cycles after the RdEn cycle into Out_Data.
//   - Sets Out_Valid=1 -> RD_RESP.
// - RD_RESP: Out_Valid and Out_Data stay stable until Out_Valid && Out_Ready.
//   - Out_Valid clears on the next cycle -> IDLE.
// - WrEn and RdEn are never high together.
// - Address and WrData hold their last values outside strobes.
// - Idle cycles between beats (In_Valid=0) are allowed in any input state; partial state is held.
// - While In_Ready=0, input frames are not consumed; the upstream must hold them.
// - RST mid-command: the command is aborted and partial frames are discarded.
//   - No WrEn/RdEn is issued for it, and any pending response is dropped.
// TESTING
// - Write: AA,02,05,00 -> one-cycle WrEn, Address=2, WrData=0x0005, one cycle after the 4th beat; no RdEn.
// - Read: after the write, BB,02 -> one RdEn at Address=2; RD_LATENCY later, Out_Data=0x0005 with Out_Valid=1.
// - Backpressure: hold Out_Ready=0 for 5 cycles during a read.
//   -> Out_Valid/Out_Data stable, In_Ready=0, and an offered AA is not consumed.
// - Bad opcode: 0x33 -> Cmd_Err pulses 1 cycle, no strobes, In_Ready stays 1; a following AA,01,13,00 writes 0x0013 to address 1.
// - Reset mid-write: AA,07,22, then RST for 1 cycle -> no WrEn.
//   - Then AA,F7,22,00 -> Address=7, WrData=0x0022.
// - Gapped stream: In_Valid low 3 cycles between every beat of BB,07 -> identical response 0x0022.

Source files
------------

// File: rtl/reg_file_access_ctrl.sv
// rtl/reg_file_access_ctrl.sv - command-stream master for the Register_file port
// Decodes WR/RD command frames into register-file strobes and returns read data.
module reg_file_access_ctrl #(
  parameter int                     DATA_WIDTH  = 16,
  parameter int                     ADDR_WIDTH  = 4,
  parameter int                     FRAME_WIDTH = 8,
  parameter logic [FRAME_WIDTH-1:0] WR_CMD      = 8'hAA,
  parameter logic [FRAME_WIDTH-1:0] RD_CMD      = 8'hBB,
  parameter int                     RD_LATENCY  = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [FRAME_WIDTH-1:0] In_Data,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  output logic                   WrEn,
  output logic                   RdEn,
  output logic [ADDR_WIDTH-1:0]  Address,
  output logic [DATA_WIDTH-1:0]  WrData,
  input  logic [DATA_WIDTH-1:0]  RdData,
  output logic [DATA_WIDTH-1:0]  Out_Data,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic                   Cmd_Err
);

  localparam int BEATS  = DATA_WIDTH / FRAME_WIDTH;
  localparam int BEAT_W = $clog2(BEATS) + 1;
  localparam int LAT_W  = $clog2(RD_LATENCY + 1) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_EXEC,
    S_RD_ADDR, S_RD_EXEC, S_RD_WAIT, S_RD_RESP
  } state_t;

  state_t                  r_state,    w_state_nxt;
  logic [BEAT_W-1:0]       r_beat,     w_beat_nxt;
  logic [LAT_W-1:0]        r_lat,      w_lat_nxt;
  logic                    r_wr_en,    w_wr_en_nxt;
  logic                    r_rd_en,    w_rd_en_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr,     w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_wr_data,  w_wr_data_nxt;
  logic [DATA_WIDTH-1:0]   r_out_data, w_out_data_nxt;
  logic                    r_out_valid, w_out_valid_nxt;
  logic                    r_cmd_err,  w_cmd_err_nxt;
  logic                    w_in_ready;
  logic                    w_accept;

  assign w_in_ready = !RST && (r_state inside {S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR});
  assign w_accept   = In_Valid && w_in_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_lat_nxt       = r_lat;
    w_wr_en_nxt     = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_addr_nxt      = r_addr;
    w_wr_data_nxt   = r_wr_data;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_cmd_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (In_Data == WR_CMD)      w_state_nxt = S_WR_ADDR;
          else if (In_Data == RD_CMD) w_state_nxt = S_RD_ADDR;
          else                        w_cmd_err_nxt = 1'b1;
        end
      end
      S_WR_ADDR: begin
        if (w_accept) begin
          w_addr_nxt  = In_Data[ADDR_WIDTH-1:0];
          w_beat_nxt  = '0;
          w_state_nxt = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        // Beats arrive least-significant frame first.
        if (w_accept) begin
          w_wr_data_nxt[r_beat * FRAME_WIDTH +: FRAME_WIDTH] = In_Data;
          if (r_beat == LAST_BEAT) begin
            w_wr_en_nxt = 1'b1;
            w_state_nxt = S_WR_EXEC;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end
      end
      S_WR_EXEC: w_state_nxt = S_IDLE;
      S_RD_ADDR: begin
        if (w_accept) begin
          w_addr_nxt  = In_Data[ADDR_WIDTH-1:0];
          w_rd_en_nxt = 1'b1;
          w_state_nxt = S_RD_EXEC;
        end
      end
      S_RD_EXEC: begin
        w_lat_nxt   = LAT_W'(1);
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // r_lat counts cycles elapsed since the RdEn cycle.
        if (r_lat == LAT_LAST) begin
          w_out_data_nxt  = RdData;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_RD_RESP;
        end else begin
          w_lat_nxt = r_lat + LAT_W'(1);
        end
      end
      S_RD_RESP: begin
        if (Out_Ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_lat       <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_wr_data   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_lat       <= w_lat_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_addr      <= w_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_cmd_err   <= w_cmd_err_nxt;
    end
  end

  assign In_Ready  = w_in_ready;
  assign WrEn      = r_wr_en;
  assign RdEn      = r_rd_en;
  assign Address   = r_addr;
  assign WrData    = r_wr_data;
  assign Out_Data  = r_out_data;
  assign Out_Valid = r_out_valid;
  assign Cmd_Err   = r_cmd_err;

endmodule
